// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: word width, alignment mask, FSM states, buffer entry.
package instr_fetch_pkg;

  localparam int          MXLEN       = 32;
  localparam logic [31:0] IALIGN_MASK = 32'h0000_0003;

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]      pc;
    logic [MXLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: boot ROM port, decode handshake, redirect request and fault report.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic [31:0]      rom_addr;
  logic [MXLEN-1:0] rom_data;
  logic             out_valid;
  logic             out_ready;
  logic [MXLEN-1:0] out_instr;
  logic [31:0]      out_pc;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             fault;
  logic [31:0]      fault_addr;

  modport master (
    output rom_addr, out_valid, out_instr, out_pc, fault, fault_addr,
    input  rom_data, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  rom_addr, out_valid, out_instr, out_pc, fault, fault_addr,
    output rom_data, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_fifo.sv
// Instruction buffer: pointer-compare FIFO with flush; head is zero while empty.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr, rptr;
  fetch_entry_t mem [DEPTH];

  // Extra pointer MSB distinguishes wrap-around full from empty.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      rptr <= wptr;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register and FETCH/FAULT control feeding a small instruction buffer.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  fetch_state_t state, state_nxt;
  logic [31:0]  pc, fault_addr;
  logic         full, empty, pop_req, pop, push, misalign;
  fetch_entry_t head;

  assign misalign = |(bus.redirect_pc & IALIGN_MASK);
  assign pop_req  = !empty && bus.out_ready;
  // A redirect flushes the buffer, so any pop in that cycle is moot.
  assign pop      = pop_req && !bus.redirect_valid;
  assign push     = (state == FETCH) && !bus.redirect_valid && (!full || pop_req);

  always_comb begin
    state_nxt = state;
    if (bus.redirect_valid) state_nxt = misalign ? FAULT : FETCH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_VECTOR;
      fault_addr <= '0;
    end else begin
      state <= state_nxt;
      if (bus.redirect_valid) begin
        if (misalign) fault_addr <= bus.redirect_pc;
        else          pc         <= bus.redirect_pc;
      end else if (push) begin
        pc <= pc + 32'd4;
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   ('{pc: pc, instr: bus.rom_data}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.rom_addr   = pc;
  assign bus.out_valid  = !empty;
  assign bus.out_instr  = head.instr;
  assign bus.out_pc     = head.pc;
  assign bus.fault      = (state == FAULT);
  assign bus.fault_addr = fault_addr;

endmodule
